wb_merge: RTL

WB_MERGE -- requirements
Module: wb_merge

---
 rtl/wb_merge_if.sv | 34 +++
 rtl/wb_merge.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/wb_merge_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_merge_if
//  Description : Bus bundle for wb_merge: main-pipeline writeback, long-latency
//                unit result handshake and register-file write port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_merge_if;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        wt_en;
    logic [4:0]  wt_addr;
    logic [31:0] wt_data;
    logic [2:0]  count;
    logic [31:0] pend_mask;

    // Producer / observer side (pipeline, long-latency unit, register file)
    modport master (
        output pipe_we, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
        input  lu_ready, wt_en, wt_addr, wt_data, count, pend_mask
    );

    // Merge block side
    modport slave (
        input  pipe_we, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
        output lu_ready, wt_en, wt_addr, wt_data, count, pend_mask
    );
endinterface
`default_nettype wire

// File: rtl/wb_merge.sv
`default_nettype none
// ============================================================================
//  Module      : wb_merge
//  Description : Merges main-pipeline writebacks with results from a
//                long-latency unit into a single register-file write port.
//                Long-latency results queue in a 4-entry FIFO; the pipeline
//                always wins arbitration. A pipeline write kills any queued
//                result for the same register so stale data never lands.
//                Optional feature macro: WB_PEND_MASK_EN (drives pend_mask).
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_merge (
    input  wire logic   clk,
    input  wire logic   rst,
    wb_merge_if.slave   bus
);
    localparam int         FIFO_DEPTH = 4;
    localparam logic [2:0] FIFO_FULL  = 3'd4;

    // FIFO storage
    logic [4:0]            ent_rd_q   [FIFO_DEPTH];
    logic [4:0]            ent_rd_d   [FIFO_DEPTH];
    logic [31:0]           ent_data_q [FIFO_DEPTH];
    logic [31:0]           ent_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] ent_live_q, ent_live_d;
    logic [1:0]            head_q, head_d;
    logic [1:0]            tail_q, tail_d;
    logic [2:0]            count_q, count_d;

    // Registered write port
    logic                  wt_en_q, wt_en_d;
    logic [4:0]            wt_addr_q, wt_addr_d;
    logic [31:0]           wt_data_q, wt_data_d;

    // Handshake / arbitration decisions
    logic                  w_lu_ready;
    logic                  w_pipe_win;
    logic                  w_push;
    logic                  w_pop;

    // Arbitration: ready uses pre-pop occupancy, pipeline beats the FIFO
    always_comb begin
        w_lu_ready = (count_q < FIFO_FULL);
        w_pipe_win = bus.pipe_we && (bus.pipe_rd != 5'd0);
        w_push     = bus.lu_valid && w_lu_ready && (bus.lu_rd != 5'd0);
        w_pop      = !w_pipe_win && (count_q != 3'd0);
    end

    // FIFO next state: push at tail, pop at head, pipeline kills matching rd
    always_comb begin
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        ent_live_d = ent_live_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (w_push) begin
            ent_rd_d[tail_q]   = bus.lu_rd;
            ent_data_d[tail_q] = bus.lu_data;
            ent_live_d[tail_q] = 1'b1;
            tail_d             = tail_q + 2'd1;
        end
        if (w_pop) begin
            // Freed slots drop their live bit so pend_mask only sees occupancy
            ent_live_d[head_q] = 1'b0;
            head_d             = head_q + 2'd1;
        end
        // Compare against post-push rd so a same-cycle push is also killed
        if (w_pipe_win) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (ent_rd_d[i] == bus.pipe_rd) begin
                    ent_live_d[i] = 1'b0;
                end
            end
        end
        count_d = count_q + {2'b00, w_push} - {2'b00, w_pop};
    end

    // Write-port next state: address/data hold when nothing is written
    always_comb begin
        wt_en_d   = 1'b0;
        wt_addr_d = wt_addr_q;
        wt_data_d = wt_data_q;
        if (w_pipe_win) begin
            wt_en_d   = 1'b1;
            wt_addr_d = bus.pipe_rd;
            wt_data_d = bus.pipe_data;
        end else if (w_pop && ent_live_q[head_q]) begin
            wt_en_d   = 1'b1;
            wt_addr_d = ent_rd_q[head_q];
            wt_data_d = ent_data_q[head_q];
        end
    end

    // State registers with asynchronous reset discarding all queued entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_rd_q[i]   <= 5'd0;
                ent_data_q[i] <= 32'd0;
            end
            ent_live_q <= '0;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            count_q    <= 3'd0;
            wt_en_q    <= 1'b0;
            wt_addr_q  <= 5'd0;
            wt_data_q  <= 32'd0;
        end else begin
            ent_rd_q   <= ent_rd_d;
            ent_data_q <= ent_data_d;
            ent_live_q <= ent_live_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            wt_en_q    <= wt_en_d;
            wt_addr_q  <= wt_addr_d;
            wt_data_q  <= wt_data_d;
        end
    end

    assign bus.lu_ready = w_lu_ready;
    assign bus.wt_en    = wt_en_q;
    assign bus.wt_addr  = wt_addr_q;
    assign bus.wt_data  = wt_data_q;
    assign bus.count    = count_q;

`ifdef WB_PEND_MASK_EN
    logic [31:0] w_pend_mask;

    // One-hot OR of destination registers still owed by the FIFO
    always_comb begin
        w_pend_mask = 32'h0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_live_q[i]) begin
                w_pend_mask[ent_rd_q[i]] = 1'b1;
            end
        end
    end

    assign bus.pend_mask = w_pend_mask;
`else
    assign bus.pend_mask = 32'h0;
`endif

endmodule
`default_nettype wire
